// File: rtl/tts_pkg.sv
// Shared types and defaults for the truth-table scanner.
// Optional ones-count output is controlled by TRUTH_TABLE_SCANNER_ONES_EN.
package tts_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int SEL_W_DEF  = 3;
  localparam int SETTLE_DEF = 1;

endpackage

// File: rtl/truth_table_scanner_if.sv
// Bus between the scanner and the function block / board-level checker.
// ones_cnt exists only when TRUTH_TABLE_SCANNER_ONES_EN is defined.
interface truth_table_scanner_if #(
  parameter int SEL_W = tts_pkg::SEL_W_DEF
);

  logic                  start;
  logic                  abort;
  logic                  f_in;
  logic [SEL_W-1:0]      W;
  logic                  En;
  logic [(2**SEL_W)-1:0] table_out;
  logic                  busy;
  logic                  done;

`ifdef TRUTH_TABLE_SCANNER_ONES_EN
  logic [SEL_W:0]        ones_cnt;

  modport master (
    input  start, abort, f_in,
    output W, En, table_out, busy, done, ones_cnt
  );

  modport slave (
    output start, abort, f_in,
    input  W, En, table_out, busy, done, ones_cnt
  );
`else
  modport master (
    input  start, abort, f_in,
    output W, En, table_out, busy, done
  );

  modport slave (
    output start, abort, f_in,
    input  W, En, table_out, busy, done
  );
`endif

endinterface

// File: rtl/settle_counter.sv
// 4-bit settle-time counter with synchronous clear and terminal count at SETTLE-1.
module settle_counter #(
  parameter int SETTLE = tts_pkg::SETTLE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam logic [3:0] TC_VAL = 4'(SETTLE - 1);

  logic [3:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/truth_table_scanner.sv
// Walks W through every code with En high, samples f after SETTLE cycles, builds the table.
// Define TRUTH_TABLE_SCANNER_ONES_EN to add the registered ones_cnt output.
module truth_table_scanner
  import tts_pkg::*;
#(
  parameter int SEL_W  = SEL_W_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input logic                   clk,
  input logic                   rst,
  truth_table_scanner_if.master bus
);

  localparam int               TBL_W     = 2**SEL_W;
  localparam logic [SEL_W-1:0] LAST_CODE = '1;

  state_e           state_q;
  logic [SEL_W-1:0] w_q;
  logic             en_q;
  logic             busy_q;
  logic             done_q;
  logic [TBL_W-1:0] table_q;
  logic [TBL_W-1:0] table_d;
  logic             settle_tc;

  settle_counter #(.SETTLE(SETTLE)) u_settle (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q != DRIVE),
    .inc_i (state_q == DRIVE),
    .tc_o  (settle_tc)
  );

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    table_d        = table_q;
    table_d[w_q]   = bus.f_in;
  end

`ifdef TRUTH_TABLE_SCANNER_ONES_EN
  logic [SEL_W:0] ones_q;
  logic [SEL_W:0] ones_d;

  // Count over the table as it will be after the final capture, so it lands with done.
  always_comb begin
    ones_d = '0;
    for (int i = 0; i < TBL_W; i++) begin
      ones_d = ones_d + (SEL_W+1)'(table_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q <= '0;
    end else if (busy_q && bus.abort) begin
      ones_q <= '0;
    end else if (state_q == IDLE && bus.start && !bus.abort) begin
      ones_q <= '0;
    end else if (state_q == SAMPLE && w_q == LAST_CODE) begin
      ones_q <= ones_d;
    end
  end

  assign bus.ones_cnt = ones_q;
`endif

  // NOTE: the table register is reset explicitly so no partial table survives rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (busy_q && bus.abort) begin
        state_q <= IDLE;
        w_q     <= '0;
        en_q    <= 1'b0;
        busy_q  <= 1'b0;
        table_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              state_q <= DRIVE;
              w_q     <= '0;
              en_q    <= 1'b1;
              busy_q  <= 1'b1;
              table_q <= '0;
            end
          end
          DRIVE: begin
            if (settle_tc) begin
              state_q <= SAMPLE;
            end
          end
          SAMPLE: begin
            table_q <= table_d;
            if (w_q == LAST_CODE) begin
              state_q <= DONE;
              w_q     <= '0;
              en_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRIVE;
              w_q     <= w_q + SEL_W'(1);
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.W         = w_q;
  assign bus.En        = en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.table_out = table_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench: stimulus queues expected tables, a negedge monitor compares on done.
`timescale 1ns/1ps
module tb_truth_table_scanner;

  localparam int SEL_W    = 3;
  localparam int TBL_W    = 8;
  localparam int SETTLE_A = 1;
  localparam int SETTLE_B = 3;
  localparam int SCAN_A   = TBL_W * (SETTLE_A + 1);
  localparam int SCAN_B   = TBL_W * (SETTLE_B + 1);

  typedef struct {
    logic [TBL_W-1:0] tbl;
    int               ones;
    int               accept;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t             exp_q[$];
  exp_t             mon_e;
  int               mon_k;
  logic [TBL_W-1:0] held_tbl;
  bit               hold_valid = 1'b0;

  logic [TBL_W-1:0] func_a = '0;
  logic             junk = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) junk <= 1'($urandom_range(1));

  truth_table_scanner_if #(.SEL_W(SEL_W)) bus_a ();
  truth_table_scanner_if #(.SEL_W(SEL_W)) bus_b ();

  // Behavioural stand-ins for the downstream function block.
  assign bus_a.f_in = bus_a.En ? func_a[bus_a.W] : junk;
  assign bus_b.f_in = bus_b.En ? 1'b1 : junk;

  truth_table_scanner #(.SEL_W(SEL_W), .SETTLE(SETTLE_A)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  truth_table_scanner #(.SEL_W(SEL_W), .SETTLE(SETTLE_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: per-cycle trace of the expected scan plus table compare on every done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_a.busy) hold_valid = 1'b0;
      if (exp_q.size() != 0) begin
        mon_k = cyc - exp_q[0].accept;
        if (mon_k >= 0 && mon_k < SCAN_A) begin
          check("trace_en_busy", {bus_a.En, bus_a.busy}, 2'b11);
          check("trace_w", bus_a.W, mon_k / (SETTLE_A + 1));
        end
      end
      if (bus_a.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_latency", cyc - mon_e.accept, SCAN_A);
          check("done_table", bus_a.table_out, mon_e.tbl);
          check("done_idle_outs", {bus_a.En, bus_a.busy, bus_a.W}, 0);
`ifdef TRUTH_TABLE_SCANNER_ONES_EN
          check("done_ones", bus_a.ones_cnt, mon_e.ones);
`endif
          held_tbl   = bus_a.table_out;
          hold_valid = 1'b1;
        end
      end else if (hold_valid) begin
        check("table_hold", bus_a.table_out, held_tbl);
      end
    end
  end

  task automatic start_scan(input logic [TBL_W-1:0] f, input bit expect_done, output int accept);
    @(negedge clk);
    func_a      = f;
    bus_a.start = 1'b1;
    accept      = cyc + 1;
    if (expect_done) exp_q.push_back('{tbl: f, ones: $countones(f), accept: accept});
    @(negedge clk);
    bus_a.start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int  a;
    int  ab;
    bit  seen;
    logic [TBL_W-1:0] f;

    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    bus_b.start = 1'b0;
    bus_b.abort = 1'b0;

    #12;
    check("rst_outs_a", {bus_a.W, bus_a.En, bus_a.table_out, bus_a.busy, bus_a.done}, 0);
    check("rst_outs_b", {bus_b.W, bus_b.En, bus_b.table_out, bus_b.busy, bus_b.done}, 0);
`ifdef TRUTH_TABLE_SCANNER_ONES_EN
    check("rst_ones", bus_a.ones_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Majority function.
    start_scan(8'hE8, 1'b1, a);
    drain(SCAN_A + 10);

    // abort together with start in IDLE: abort wins, table is kept.
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.abort = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    check("abort_start_idle", {bus_a.busy, bus_a.En, bus_a.table_out}, {2'b00, 8'hE8});
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      f = TBL_W'($urandom);
      start_scan(f, 1'b1, a);
      drain(SCAN_A + 10);
    end

    // abort during SAMPLE of W=4 with ones already captured.
    start_scan(8'hFF, 1'b0, a);
    wait_cycle(a + 4 * (SETTLE_A + 1) + SETTLE_A);
    check("pre_abort_w", {bus_a.En, bus_a.W}, {1'b1, 3'd4});
    bus_a.abort = 1'b1;
    @(negedge clk);
    bus_a.abort = 1'b0;
    check("abort_outs", {bus_a.En, bus_a.W, bus_a.busy, bus_a.done}, 0);
    check("abort_table", bus_a.table_out, 0);
`ifdef TRUTH_TABLE_SCANNER_ONES_EN
    check("abort_ones", bus_a.ones_cnt, 0);
`endif
    repeat (SCAN_A + 4) @(negedge clk);

    // rst pulse during DRIVE of W=2.
    start_scan(8'hFF, 1'b0, a);
    wait_cycle(a + 2 * (SETTLE_A + 1));
    #1 rst = 1'b1;
    #1 check("midscan_rst", {bus_a.W, bus_a.En, bus_a.table_out, bus_a.busy, bus_a.done}, 0);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    start_scan(8'h5A, 1'b1, a);
    drain(SCAN_A + 10);

    // start held high: back-to-back scans, one IDLE cycle between done and accept.
    @(negedge clk);
    func_a      = TBL_W'($urandom);
    bus_a.start = 1'b1;
    a           = cyc + 1;
    for (int i = 0; i < 3; i++)
      exp_q.push_back('{tbl: func_a, ones: $countones(func_a), accept: a + i * (SCAN_A + 2)});
    wait_cycle(a + 2 * (SCAN_A + 2));
    bus_a.start = 1'b0;
    drain(SCAN_A + 10);

    // start pulsed while busy at W=3: no restart, single done.
    start_scan(8'h3C, 1'b1, a);
    wait_cycle(a + 3 * (SETTLE_A + 1));
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    drain(SCAN_A + 10);
    repeat (SCAN_A + 4) @(negedge clk);
    check("after_busy_start", bus_a.busy, 0);

    // Longer settle time on the second instance, constant-1 function.
    @(negedge clk);
    bus_b.start = 1'b1;
    ab          = cyc + 1;
    @(negedge clk);
    bus_b.start = 1'b0;
    seen        = 1'b0;
    for (int k = 0; k < SCAN_B + 8 && !seen; k++) begin
      if (bus_b.done) begin
        seen = 1'b1;
        check("b_done_cycle", cyc - ab, SCAN_B);
        check("b_table", bus_b.table_out, 8'hFF);
`ifdef TRUTH_TABLE_SCANNER_ONES_EN
        check("b_ones", bus_b.ones_cnt, 8);
`endif
      end else begin
        if (k < SCAN_B) check("b_trace", {bus_b.En, bus_b.W}, {1'b1, 3'(k / (SETTLE_B + 1))});
        @(negedge clk);
      end
    end
    if (!seen) check("b_done_timeout", 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
